// File: rtl/reg_write_port.sv
// ---------------------------------------------------------------------------
// reg_write_port
//
// Write side of the general-purpose register file. Write-back requests
// (rd, data) go into a small in-order queue. They drain one per cycle into a
// registered write port whenever the register file is not busy. Writes to r0
// are discarded because r0 is hardwired to zero. Decode uses the per-operand
// pending flags to stall on read-after-write hazards.
//
// Ports
//   clk        clock
//   reset      synchronous, active-high reset
//   req_valid  write-back request valid
//   req_ready  queue can accept a request (queue not full)
//   req_rd     destination register of the request
//   req_data   value to write
//   wr_stall   register file busy; nothing is popped this cycle
//   wr_en      registered register-file write strobe
//   wr_addr    registered write address (holds when wr_en is low)
//   wr_data    registered write data (holds when wr_en is low)
//   rs1, rs2   decode operand addresses
//   rs1_pend   a write to rs1 is queued or being written
//   rs2_pend   a write to rs2 is queued or being written
//   count      queue occupancy
//   idle       queue empty and no write in flight
// ---------------------------------------------------------------------------
module reg_write_port #(
  parameter int REG_BITS_SIZE = 5,
  parameter int INST_SIZE     = 32,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [REG_BITS_SIZE-1:0] req_rd,
  input  logic [INST_SIZE-1:0]     req_data,
  input  logic                     wr_stall,
  output logic                     wr_en,
  output logic [REG_BITS_SIZE-1:0] wr_addr,
  output logic [INST_SIZE-1:0]     wr_data,
  input  logic [REG_BITS_SIZE-1:0] rs1,
  input  logic [REG_BITS_SIZE-1:0] rs2,
  output logic                     rs1_pend,
  output logic                     rs2_pend,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     idle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [REG_BITS_SIZE-1:0] r_memRd   [DEPTH];
  logic [INST_SIZE-1:0]     r_memData [DEPTH];
  logic [DEPTH-1:0]         r_valid;
  logic [PTR_W-1:0]         r_head;
  logic [PTR_W-1:0]         r_tail;
  logic [PTR_W:0]           r_count;
  logic                     r_wrEn;
  logic [REG_BITS_SIZE-1:0] r_wrAddr;
  logic [INST_SIZE-1:0]     r_wrData;

  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_rs1Hit;
  logic w_rs2Hit;

  // Full is judged on the current occupancy only, so a pop in the same
  // cycle never opens the queue to a new request.
  assign w_full = (r_count == FULL_COUNT);
  // A request to r0 is handshaken (ready stays high) but never stored.
  assign w_push = req_valid && !w_full && (req_rd != '0);
  assign w_pop  = (r_count != '0) && !wr_stall;

  // Queue payload storage needs no reset; occupancy is tracked by r_valid
  // and r_count, so stale payload is never observed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_memRd[r_tail]   <= req_rd;
      r_memData[r_tail] <= req_data;
    end
  end

  // Pointers, occupancy, per-entry valid bits and the registered write port.
  // Pointers are PTR_W bits wide, so they wrap naturally at DEPTH. Head and
  // tail can only coincide when the queue is empty or full, and in those
  // cases a push and a pop never happen together. Clearing and setting
  // r_valid in the same cycle therefore always touch different entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_valid  <= '0;
      r_wrEn   <= 1'b0;
      r_wrAddr <= '0;
      r_wrData <= '0;
    end else begin
      r_wrEn <= w_pop;
      if (w_pop) begin
        r_wrAddr        <= r_memRd[r_head];
        r_wrData        <= r_memData[r_head];
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Hazard search: any live queue entry or the write currently on the port
  // that targets the operand. A request being accepted this cycle is not
  // yet in r_valid, so it is not counted.
  always_comb begin
    w_rs1Hit = r_wrEn && (r_wrAddr == rs1);
    w_rs2Hit = r_wrEn && (r_wrAddr == rs2);
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_memRd[i] == rs1)) w_rs1Hit = 1'b1;
      if (r_valid[i] && (r_memRd[i] == rs2)) w_rs2Hit = 1'b1;
    end
  end

  assign rs1_pend  = (rs1 != '0) && w_rs1Hit;
  assign rs2_pend  = (rs2 != '0) && w_rs2Hit;
  assign req_ready = !w_full;
  assign wr_en     = r_wrEn;
  assign wr_addr   = r_wrAddr;
  assign wr_data   = r_wrData;
  assign count     = r_count;
  assign idle      = (r_count == '0) && !r_wrEn;

endmodule

// File: tb/tb_reg_write_port.sv
// ---------------------------------------------------------------------------
// tb_reg_write_port
//
// Self-checking bench for reg_write_port. A queue-based reference model
// tracks what the write port must show after every clock edge. A negedge
// compare process checks all outputs against it. Directed scenarios also
// pin hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_reg_write_port;

  localparam int REG_BITS_SIZE = 5;
  localparam int INST_SIZE     = 32;
  localparam int DEPTH         = 4;
  localparam int CNT_W         = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [REG_BITS_SIZE-1:0] rd;
    logic [INST_SIZE-1:0]     data;
  } entry_t;

  logic                     clk;
  logic                     reset;
  logic                     req_valid;
  logic                     req_ready;
  logic [REG_BITS_SIZE-1:0] req_rd;
  logic [INST_SIZE-1:0]     req_data;
  logic                     wr_stall;
  logic                     wr_en;
  logic [REG_BITS_SIZE-1:0] wr_addr;
  logic [INST_SIZE-1:0]     wr_data;
  logic [REG_BITS_SIZE-1:0] rs1;
  logic [REG_BITS_SIZE-1:0] rs2;
  logic                     rs1_pend;
  logic                     rs2_pend;
  logic [CNT_W-1:0]         count;
  logic                     idle;

  int totalChecks  = 0;
  int passedChecks = 0;

  // Reference model state
  entry_t                   modelQ[$];
  logic                     mWrEn   = 1'b0;
  logic [REG_BITS_SIZE-1:0] mWrAddr = '0;
  logic [INST_SIZE-1:0]     mWrData = '0;
  bit                       checkEn = 1'b0;

  reg_write_port #(
    .REG_BITS_SIZE(REG_BITS_SIZE),
    .INST_SIZE(INST_SIZE),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rd(req_rd),
    .req_data(req_data),
    .wr_stall(wr_stall),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rs1(rs1),
    .rs2(rs2),
    .rs1_pend(rs1_pend),
    .rs2_pend(rs2_pend),
    .count(count),
    .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared comparison routine for both the compare process and literal checks
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    totalChecks++;
    if (actual === expected) begin
      passedChecks++;
    end else begin
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive the request/stall inputs; takes effect at the next rising edge
  task automatic applyStimulus(input logic valid, input logic [REG_BITS_SIZE-1:0] rd,
                               input logic [INST_SIZE-1:0] data, input logic stall);
    req_valid = valid;
    req_rd    = rd;
    req_data  = data;
    wr_stall  = stall;
  endtask

  // Advance one edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pending flag from the model: any queued write or the write on the port
  function automatic bit expPend(input logic [REG_BITS_SIZE-1:0] rs);
    bit hit;
    hit = mWrEn && (mWrAddr == rs);
    foreach (modelQ[i]) if (modelQ[i].rd == rs) hit = 1'b1;
    return (rs != '0) && hit;
  endfunction

  // Model update on every rising edge. Readiness and the pop decision use
  // the occupancy seen before the edge. r0 requests are handshaken but never
  // stored.
  always @(posedge clk) begin
    int     sz;
    bit     accept;
    entry_t e;
    if (reset) begin
      modelQ.delete();
      mWrEn   = 1'b0;
      mWrAddr = '0;
      mWrData = '0;
      checkEn = 1'b1;
    end else begin
      sz     = modelQ.size();
      accept = req_valid && (sz != DEPTH) && (req_rd != '0);
      if (sz != 0 && !wr_stall) begin
        e       = modelQ.pop_front();
        mWrEn   = 1'b1;
        mWrAddr = e.rd;
        mWrData = e.data;
      end else begin
        mWrEn = 1'b0;
      end
      if (accept) begin
        e.rd   = req_rd;
        e.data = req_data;
        modelQ.push_back(e);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("cmpReady", 64'(req_ready), 64'(modelQ.size() != DEPTH));
      checkOutput("cmpCount", 64'(count), 64'(modelQ.size()));
      checkOutput("cmpIdle", 64'(idle), 64'((modelQ.size() == 0) && !mWrEn));
      checkOutput("cmpWrEn", 64'(wr_en), 64'(mWrEn));
      checkOutput("cmpWrAddr", 64'(wr_addr), 64'(mWrAddr));
      checkOutput("cmpWrData", 64'(wr_data), 64'(mWrData));
      checkOutput("cmpRs1Pend", 64'(rs1_pend), 64'(expPend(rs1)));
      checkOutput("cmpRs2Pend", 64'(rs2_pend), 64'(expPend(rs2)));
    end
  end

  // Absolute time limit so the bench always ends
  initial begin
    #200000;
    $display("[TB] FAIL timeout simulation did not finish actual=running expected=done");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b1;
    rs1   = '0;
    rs2   = '0;
    applyStimulus(1'b0, '0, '0, 1'b0);

    // 1. Reset for two cycles
    step();
    step();
    checkOutput("rstReady", 64'(req_ready), 64'd1);
    checkOutput("rstWrEn", 64'(wr_en), 64'd0);
    checkOutput("rstCount", 64'(count), 64'd0);
    checkOutput("rstIdle", 64'(idle), 64'd1);
    reset = 1'b0;
    step();

    // 2. Single write, latency and rs1 pending window
    rs1 = 5'd5;
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    step();
    checkOutput("t2Count", 64'(count), 64'd1);
    checkOutput("t2WrEnE0", 64'(wr_en), 64'd0);
    checkOutput("t2PendE0", 64'(rs1_pend), 64'd1);
    applyStimulus(1'b0, '0, '0, 1'b0);
    step();
    checkOutput("t2WrEnE1", 64'(wr_en), 64'd1);
    checkOutput("t2WrAddr", 64'(wr_addr), 64'd5);
    checkOutput("t2WrData", 64'(wr_data), 64'hDEADBEEF);
    checkOutput("t2PendE1", 64'(rs1_pend), 64'd1);
    step();
    checkOutput("t2WrEnE2", 64'(wr_en), 64'd0);
    checkOutput("t2PendE2", 64'(rs1_pend), 64'd0);
    checkOutput("t2Idle", 64'(idle), 64'd1);

    // 3. Write to r0 is consumed and dropped
    rs1 = 5'd0;
    applyStimulus(1'b1, 5'd0, 32'h1234, 1'b0);
    step();
    checkOutput("t3Count", 64'(count), 64'd0);
    checkOutput("t3Pend", 64'(rs1_pend), 64'd0);
    applyStimulus(1'b0, '0, '0, 1'b0);
    step();
    checkOutput("t3WrEnA", 64'(wr_en), 64'd0);
    step();
    checkOutput("t3WrEnB", 64'(wr_en), 64'd0);

    // 4. Fill under stall, fifth request held, then drain in order
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 5'(i), 32'(100 + i), 1'b1);
      step();
      if (i == 4) checkOutput("t4ReadyFull", 64'(req_ready), 64'd0);
    end
    checkOutput("t4CountHeld", 64'(count), 64'd4);
    rs1 = 5'd3;
    rs2 = 5'd7;
    #1;
    checkOutput("t4Rs1Pend", 64'(rs1_pend), 64'd1);
    checkOutput("t4Rs2Pend", 64'(rs2_pend), 64'd0);
    applyStimulus(1'b1, 5'd5, 32'd105, 1'b0);
    step();
    checkOutput("t4Pop1En", 64'(wr_en), 64'd1);
    checkOutput("t4Pop1Addr", 64'(wr_addr), 64'd1);
    checkOutput("t4Pop1Count", 64'(count), 64'd3);
    step();
    checkOutput("t4Pop2Addr", 64'(wr_addr), 64'd2);
    checkOutput("t4Pop2Count", 64'(count), 64'd3);
    applyStimulus(1'b0, '0, '0, 1'b0);
    for (int i = 3; i <= 5; i++) begin
      step();
      checkOutput("t4PopEn", 64'(wr_en), 64'd1);
      checkOutput("t4PopAddr", 64'(wr_addr), 64'(i));
      checkOutput("t4PopData", 64'(wr_data), 64'(100 + i));
    end
    step();
    checkOutput("t4DoneIdle", 64'(idle), 64'd1);

    // 5. Simultaneous push/pop at count 2, order across pointer wrap
    rs1 = 5'd12;
    rs2 = 5'd17;
    applyStimulus(1'b1, 5'd10, 32'hA0, 1'b1);
    step();
    applyStimulus(1'b1, 5'd11, 32'hA1, 1'b1);
    step();
    checkOutput("t5CountTwo", 64'(count), 64'd2);
    for (int i = 12; i <= 17; i++) begin
      applyStimulus(1'b1, 5'(i), 32'(8'hA0 + i - 10), 1'b0);
      step();
      checkOutput("t5CountSteady", 64'(count), 64'd2);
      checkOutput("t5PopAddr", 64'(wr_addr), 64'(i - 2));
    end
    applyStimulus(1'b0, '0, '0, 1'b0);
    for (int n = 0; n < 20 && !idle; n++) step();
    checkOutput("t5DrainIdle", 64'(idle), 64'd1);
    checkOutput("t5LastAddr", 64'(wr_addr), 64'd17);
    checkOutput("t5LastData", 64'(wr_data), 64'hA7);

    // 6. Reset discards queued writes
    for (int i = 20; i <= 22; i++) begin
      applyStimulus(1'b1, 5'(i), 32'(i), 1'b1);
      step();
    end
    checkOutput("t6CountPre", 64'(count), 64'd3);
    applyStimulus(1'b0, '0, '0, 1'b1);
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i);
      rs2 = 5'(31 - i);
      step();
      checkOutput("t6Rs1Pend", 64'(rs1_pend), 64'd0);
      checkOutput("t6Rs2Pend", 64'(rs2_pend), 64'd0);
    end
    checkOutput("t6Count", 64'(count), 64'd0);
    checkOutput("t6WrEn", 64'(wr_en), 64'd0);
    reset = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0);
    rs1 = 5'd21;
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("t6NoWrite", 64'(wr_en), 64'd0);
    end

    @(posedge clk);
    $display("%0d/%0d checks passed", passedChecks, totalChecks);
    $finish;
  end

endmodule
